// File: rtl/regfile_wr_sb_if.sv
// rtl/regfile_wr_sb_if.sv - write, read, issue-mark and scoreboard signals of regfile_wr_sb
interface regfile_wr_sb_if #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
);
    logic                we;
    logic [ADDR_W-1:0]   waddr;
    logic [DATA_W-1:0]   wdata;
    logic [NUM_REGS-1:0] wr_load;
    logic [ADDR_W-1:0]   raddr_a;
    logic [DATA_W-1:0]   rdata_a;
    logic                busy_a;
    logic [ADDR_W-1:0]   raddr_b;
    logic [DATA_W-1:0]   rdata_b;
    logic                busy_b;
    logic                mark_en;
    logic [ADDR_W-1:0]   mark_addr;
    logic [ADDR_W:0]     busy_cnt;

    modport master (
        output we, waddr, wdata, raddr_a, raddr_b, mark_en, mark_addr,
        input  wr_load, rdata_a, busy_a, rdata_b, busy_b, busy_cnt
    );

    modport slave (
        input  we, waddr, wdata, raddr_a, raddr_b, mark_en, mark_addr,
        output wr_load, rdata_a, busy_a, rdata_b, busy_b, busy_cnt
    );
endinterface

// File: rtl/regfile_wr_sb.sv
// rtl/regfile_wr_sb.sv - register file with decoded write port, two read ports and busy scoreboard; optional REGFILE_BYPASS_EN
module regfile_wr_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int ZERO_REG = 1
) (
    input  logic           clk,
    input  logic           rst,
    regfile_wr_sb_if.slave rf
);
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [NUM_REGS-1:0] wr_load_v;
    logic [NUM_REGS-1:0] set_v;
    logic [ADDR_W:0]     busy_cnt_q;
    logic [ADDR_W:0]     cnt_nxt;
    logic [DATA_W-1:0]   rd_a;
    logic [DATA_W-1:0]   rd_b;
    logic                bz_a;
    logic                bz_b;

    function automatic logic writable(int i);
        return !(ZERO_REG != 0 && i == 0);
    endfunction

    // Decoding against every implemented index drops out-of-range addresses for free.
    always_comb begin
        wr_load_v = '0;
        set_v     = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_load_v[i] = rf.we && (rf.waddr == ADDR_W'(i)) && writable(i);
            set_v[i]     = rf.mark_en && (rf.mark_addr == ADDR_W'(i)) && writable(i);
        end
    end

    // A new producer marked in the same cycle as the old one writes back keeps the bit set.
    always_comb begin
        busy_nxt = (busy & ~wr_load_v) | set_v;
        cnt_nxt  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= '0;
            busy_cnt_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            busy       <= busy_nxt;
            busy_cnt_q <= cnt_nxt;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_load_v[i]) begin
                    regs[i] <= rf.wdata;
                end
            end
        end
    end

    // Read mux; the hardwired zero register is never written, so it always reads 0.
    always_comb begin
        rd_a = '0;
        bz_a = 1'b0;
        rd_b = '0;
        bz_b = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rf.raddr_a == ADDR_W'(i)) begin
                rd_a = regs[i];
                bz_a = busy[i];
`ifdef REGFILE_BYPASS_EN
                if (wr_load_v[i]) begin
                    rd_a = rf.wdata;
                    bz_a = set_v[i];
                end
`endif
            end
            if (rf.raddr_b == ADDR_W'(i)) begin
                rd_b = regs[i];
                bz_b = busy[i];
`ifdef REGFILE_BYPASS_EN
                if (wr_load_v[i]) begin
                    rd_b = rf.wdata;
                    bz_b = set_v[i];
                end
`endif
            end
        end
    end

    assign rf.wr_load  = wr_load_v;
    assign rf.rdata_a  = rd_a;
    assign rf.busy_a   = bz_a;
    assign rf.rdata_b  = rd_b;
    assign rf.busy_b   = bz_b;
    assign rf.busy_cnt = busy_cnt_q;
endmodule
